// File: rtl/press_classifier.sv
// -----------------------------------------------------------------------------
// press_classifier
//
// Turns the conditioned button stream (debounced level plus press/release
// pulses, 2 kHz clock) into game commands: short press, double press, long
// press and auto-repeat while a long press is held. Every command output is a
// registered, single-cycle pulse, and at most one of them is high in any cycle.
//
// Ports
//   i_Clk          2 kHz system clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   i_ButtonDeb    debounced button level, 0 = pressed
//   i_ButtonDown   one-cycle pulse on press
//   i_ButtonUp     one-cycle pulse on release
//   o_ShortPress   single short press confirmed
//   o_DoublePress  double press confirmed
//   o_LongPress    hold reached LONG_TICKS
//   o_Repeat       every REPEAT_TICKS while held after a long press
//   o_Busy         high whenever a gesture is in progress (state not IDLE)
// -----------------------------------------------------------------------------
module press_classifier #(
    parameter int CNT_W        = 12,
    parameter int MIN_TICKS    = 40,
    parameter int DOUBLE_TICKS = 500,
    parameter int LONG_TICKS   = 2000,
    parameter int REPEAT_TICKS = 400
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_ButtonDeb,
    input  logic i_ButtonDown,
    input  logic i_ButtonUp,
    output logic o_ShortPress,
    output logic o_DoublePress,
    output logic o_LongPress,
    output logic o_Repeat,
    output logic o_Busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        HELD,
        WAIT_REL
    } stateT;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_TICKS);
    localparam logic [CNT_W-1:0] DOUBLE_C    = CNT_W'(DOUBLE_TICKS);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    stateT            state;
    logic [CNT_W-1:0] count;
    logic             debPrev;

    logic downEv;
    logic upEv;
    logic missedRel;

    // Down and Up together cannot come from a sane upstream; both are dropped.
    assign downEv = i_ButtonDown & ~i_ButtonUp;
    assign upEv   = i_ButtonUp & ~i_ButtonDown;

    // Level released for two cycles in a row with no Up pulse: the release
    // pulse was lost upstream, so treat the button as released anyway.
    assign missedRel = i_ButtonDeb & debPrev & ~i_ButtonUp;

    // Within each state the edge tests come before the timeout tests, so an
    // edge arriving on the timeout cycle always takes precedence.
    // NOTE: every register here is assigned with <= so all of them update
    // together from the same pre-edge values; a blocking = would let later
    // statements see half-updated state.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= IDLE;
            count         <= '0;
            debPrev       <= 1'b1;
            o_ShortPress  <= 1'b0;
            o_DoublePress <= 1'b0;
            o_LongPress   <= 1'b0;
            o_Repeat      <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            debPrev       <= i_ButtonDeb;
            o_ShortPress  <= 1'b0;
            o_DoublePress <= 1'b0;
            o_LongPress   <= 1'b0;
            o_Repeat      <= 1'b0;

            // Saturating tick counter; any transition below overrides it with 0.
            if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (downEv) begin
                        state  <= PRESS1;
                        count  <= '0;
                        o_Busy <= 1'b1;
                    end
                end

                PRESS1: begin
                    if (upEv || missedRel) begin
                        count <= '0;
                        if (count < MIN_C) begin
                            state  <= IDLE;    // too short: glitch, no command
                            o_Busy <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (count == LONG_LAST) begin
                        state       <= HELD;
                        count       <= '0;
                        o_LongPress <= 1'b1;
                    end
                end

                GAP: begin
                    if (downEv && (count < DOUBLE_C)) begin
                        state <= PRESS2;
                        count <= '0;
                    end else if (count == DOUBLE_LAST) begin
                        state        <= IDLE;
                        count        <= '0;
                        o_Busy       <= 1'b0;
                        o_ShortPress <= 1'b1;
                    end
                end

                PRESS2: begin
                    if (upEv) begin
                        state         <= IDLE;
                        count         <= '0;
                        o_Busy        <= 1'b0;
                        o_DoublePress <= 1'b1;
                    end else if (missedRel) begin
                        state  <= IDLE;
                        count  <= '0;
                        o_Busy <= 1'b0;
                    end else if (count == LONG_LAST) begin
                        // Report the double now; the rest of the hold is ignored.
                        state         <= WAIT_REL;
                        count         <= '0;
                        o_DoublePress <= 1'b1;
                    end
                end

                HELD: begin
                    if (upEv || missedRel) begin
                        state  <= IDLE;
                        count  <= '0;
                        o_Busy <= 1'b0;
                    end else if (count == REPEAT_LAST) begin
                        count    <= '0;
                        o_Repeat <= 1'b1;
                    end
                end

                WAIT_REL: begin
                    if (upEv || missedRel) begin
                        state  <= IDLE;
                        count  <= '0;
                        o_Busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_press_classifier
//
// Gesture-level bench. Each gesture (first press, optional second press, idle
// tail) is planned up front; a reference model derives the expected command
// pulses from the press/release edge numbers with plain arithmetic and pushes
// them into a queue. An independent monitor samples the outputs on every
// falling edge and compares whatever it sees against the queue head.
// -----------------------------------------------------------------------------
module tb_press_classifier;

    localparam int CNT_W        = 12;
    localparam int MIN_TICKS    = 40;
    localparam int DOUBLE_TICKS = 500;
    localparam int LONG_TICKS   = 2000;
    localparam int REPEAT_TICKS = 400;

    localparam int K_SHORT  = 0;
    localparam int K_DOUBLE = 1;
    localparam int K_LONG   = 2;
    localparam int K_REPEAT = 3;

    typedef struct {
        int at;     // rising-edge number after which the pulse is visible
        int kind;
    } expT;

    logic i_Clk;
    logic i_Rst_n;
    logic i_ButtonDeb;
    logic i_ButtonDown;
    logic i_ButtonUp;
    logic o_ShortPress;
    logic o_DoublePress;
    logic o_LongPress;
    logic o_Repeat;
    logic o_Busy;

    int   checks   = 0;
    int   failures = 0;
    int   edgeCnt  = 0;
    expT  expq[$];

    logic [3:0] seen;
    logic [3:0] expVec;

    press_classifier #(
        .CNT_W        (CNT_W),
        .MIN_TICKS    (MIN_TICKS),
        .DOUBLE_TICKS (DOUBLE_TICKS),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_ButtonDeb   (i_ButtonDeb),
        .i_ButtonDown  (i_ButtonDown),
        .i_ButtonUp    (i_ButtonUp),
        .o_ShortPress  (o_ShortPress),
        .o_DoublePress (o_DoublePress),
        .o_LongPress   (o_LongPress),
        .o_Repeat      (o_Repeat),
        .o_Busy        (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) edgeCnt <= edgeCnt + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCnt);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void expectPulse(input int at, input int kind);
        expT e;
        e.at   = at;
        e.kind = kind;
        expq.push_back(e);
    endfunction

    // A press starting in IDLE: Down sampled at edge d, release taking effect
    // at edge ue. Returns 1 when the press was a valid non-long press and a
    // second press may still turn it into a double.
    function automatic bit firstPress(input int d, input int ue);
        int len;
        len = ue - d;
        if (len <= MIN_TICKS) return 1'b0;
        if (len > LONG_TICKS) begin
            expectPulse(d + LONG_TICKS, K_LONG);
            for (int e = d + LONG_TICKS + REPEAT_TICKS; e < ue; e += REPEAT_TICKS)
                expectPulse(e, K_REPEAT);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic idle(input int n);
        i_ButtonDeb  = 1'b1;
        i_ButtonDown = 1'b0;
        i_ButtonUp   = 1'b0;
        step(n);
    endtask

    // Down sampled at the next edge d, level low for len cycles, level high
    // again at edge d+len, with or without the Up pulse.
    task automatic press(input int len, input bit useUp);
        i_ButtonDown = 1'b1;
        i_ButtonDeb  = 1'b0;
        step(1);
        i_ButtonDown = 1'b0;
        check("busy_in_press", int'(o_Busy), 1);
        step(len - 1);
        i_ButtonDeb = 1'b1;
        i_ButtonUp  = useUp;
        step(1);
        i_ButtonUp = 1'b0;
    endtask

    // gap == 0: no second press. Otherwise the second Down is sampled gap
    // edges after the first release edge. The second press always sends Up.
    task automatic gesture(input int l1, input bit missed, input int gap,
                           input int l2, input int tail);
        int d1, ue1, d2, u2;
        bit armed;
        d1    = edgeCnt + 1;
        ue1   = d1 + l1 + int'(missed);   // lost Up is noticed one cycle late
        armed = firstPress(d1, ue1);
        if (gap > 0) begin
            d2 = d1 + l1 + gap;
            u2 = d2 + l2;
            if (armed && (d2 - ue1) <= DOUBLE_TICKS) begin
                expectPulse((l2 <= LONG_TICKS) ? u2 : d2 + LONG_TICKS, K_DOUBLE);
            end else begin
                if (armed) expectPulse(ue1 + DOUBLE_TICKS, K_SHORT);
                if (firstPress(d2, u2)) expectPulse(u2 + DOUBLE_TICKS, K_SHORT);
            end
        end else if (armed) begin
            expectPulse(ue1 + DOUBLE_TICKS, K_SHORT);
        end

        press(l1, !missed);
        if (!missed && l1 <= MIN_TICKS) check("busy_after_glitch", int'(o_Busy), 0);
        if (gap > 0) begin
            idle(gap - 1);
            press(l2, 1'b1);
        end
        idle(tail);
        check("busy_after_gesture", int'(o_Busy), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_Clk) begin
        expVec = 4'b0000;
        if (expq.size() > 0 && expq[0].at == edgeCnt)
            expVec = 4'b0001 << expq[0].kind;
        seen = {o_Repeat, o_LongPress, o_DoublePress, o_ShortPress};
        if (expVec != 4'b0000 || seen != 4'b0000)
            check("pulses{rep,long,dbl,short}", int'(seen), int'(expVec));
        if (expVec != 4'b0000)
            void'(expq.pop_front());
    end

    // ---------------- test sequence ----------------
    initial begin
        int cat, l1, gap, l2, tail;
        bit missed;

        i_Rst_n      = 1'b0;
        i_ButtonDeb  = 1'b1;
        i_ButtonDown = 1'b0;
        i_ButtonUp   = 1'b0;
        step(3);
        check("rst_busy",   int'(o_Busy), 0);
        check("rst_short",  int'(o_ShortPress), 0);
        check("rst_double", int'(o_DoublePress), 0);
        check("rst_long",   int'(o_LongPress), 0);
        check("rst_repeat", int'(o_Repeat), 0);
        i_Rst_n = 1'b1;
        idle(5);

        // Directed gestures
        gesture(100,  1'b0, 0,   0,   600);   // short, 500 after release
        gesture(20,   1'b0, 0,   0,   10);    // glitch, nothing
        gesture(100,  1'b0, 200, 100, 600);   // double on second release
        gesture(3000, 1'b0, 0,   0,   600);   // long at 2000, repeats 2400/2800
        gesture(100,  1'b0, 500, 100, 600);   // second Down at GAP count 499
        gesture(100,  1'b0, 501, 100, 600);   // at count 500: short + fresh press
        gesture(100,  1'b1, 0,   0,   600);   // lost Up pulse on a short press
        gesture(2500, 1'b1, 0,   0,   100);   // lost Up pulse while held

        // Reset in the middle of a hold
        i_ButtonDown = 1'b1;
        i_ButtonDeb  = 1'b0;
        step(1);
        i_ButtonDown = 1'b0;
        step(999);
        check("busy_before_abort", int'(o_Busy), 1);
        i_Rst_n = 1'b0;
        #1;
        check("abort_busy",   int'(o_Busy), 0);
        check("abort_short",  int'(o_ShortPress), 0);
        check("abort_double", int'(o_DoublePress), 0);
        check("abort_long",   int'(o_LongPress), 0);
        check("abort_repeat", int'(o_Repeat), 0);
        step(3);
        i_Rst_n = 1'b1;
        step(5);
        i_ButtonDeb = 1'b1;         // lone release after reset: ignored
        i_ButtonUp  = 1'b1;
        step(1);
        i_ButtonUp = 1'b0;
        check("busy_after_lone_up", int'(o_Busy), 0);
        idle(600);
        gesture(100, 1'b0, 0, 0, 600);

        // Randomised gestures around the thresholds
        for (int g = 0; g < 10; g++) begin
            cat = int'($urandom_range(0, 3));
            case (cat)
                0:       l1 = int'($urandom_range(1, 80));
                1:       l1 = int'($urandom_range(41, 600));
                2:       l1 = int'($urandom_range(1990, 2010));
                default: l1 = int'($urandom_range(2300, 2600));
            endcase
            missed = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       gap = 0;
                1:       gap = int'($urandom_range(2, 700));
                2:       gap = int'($urandom_range(495, 505));
                default: gap = int'($urandom_range(2, 300));
            endcase
            if ($urandom_range(0, 4) == 0) l2 = int'($urandom_range(1995, 2100));
            else                           l2 = int'($urandom_range(1, 150));
            tail = DOUBLE_TICKS + int'($urandom_range(5, 60));
            gesture(l1, missed, gap, l2, tail);
        end

        step(5);
        check("leftover_expectations", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
